// File: rtl/arb_pri_8_v.sv
// Eight-requester arbiter: fixed-priority or round-robin selection,
// grant held until release, request drop or hold timeout, then one dead cycle.
module arb_pri_8_v #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic       i_rr_mode,
  input  logic       i_done,
  output logic [7:0] o_grant,
  output logic [2:0] o_grant_code,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       last_id, last_id_nx;
  logic [7:0]       grant_nx;
  logic [2:0]       code_nx;
  logic             busy_nx;
  logic             to_nx;
  logic [2:0]       fp_id, rr_id, win_id;
  logic             rr_hit;
  logic             rel, hit;

  // Later iterations overwrite, so the highest set bit wins.
  always_comb begin
    fp_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_req[i]) fp_id = 3'(i);
    end
  end

  // Search starts just past the last owner; 3-bit sum wraps 7 -> 0.
  always_comb begin
    rr_id  = '0;
    rr_hit = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!rr_hit && i_req[last_id + 3'(i)]) begin
        rr_id  = last_id + 3'(i);
        rr_hit = 1'b1;
      end
    end
  end

  assign win_id = i_rr_mode ? rr_id : fp_id;
  assign rel    = i_done || !i_req[o_grant_code];
  assign hit    = (HOLD_MAX != 0) && (cnt == HOLD_LAST);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    last_id_nx = last_id;
    grant_nx   = o_grant;
    code_nx    = o_grant_code;
    busy_nx    = o_busy;
    to_nx      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|i_req) begin
          state_nx = GRANT;
          cnt_nx   = '0;
          grant_nx = 8'b1 << win_id;
          code_nx  = win_id;
          busy_nx  = 1'b1;
        end
      end
      GRANT: begin
        cnt_nx = cnt + 1'b1;
        if (rel || hit) begin
          state_nx   = GAP;
          grant_nx   = '0;
          code_nx    = '0;
          busy_nx    = 1'b0;
          last_id_nx = o_grant_code;
          to_nx      = hit && !rel;
        end
      end
      GAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_id      <= 3'd7;
      o_grant      <= '0;
      o_grant_code <= '0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      last_id      <= last_id_nx;
      o_grant      <= grant_nx;
      o_grant_code <= code_nx;
      o_busy       <= busy_nx;
      o_timeout    <= to_nx;
    end
  end

endmodule

// File: doc/arb_pri_8_v.md
# arb_pri_8_v

Eight-requester arbiter that shares one downstream resource, such as a bus or datapath port, among up to eight agents. It selects a winner either by fixed priority (bit 7 highest, the same ordering as the 8-to-3 priority encoder) or by round-robin. It holds the grant until the owner releases it or a hold-timeout expires. The resource control logic instantiates it wherever `i_code`-style request vectors would otherwise feed a bare priority encoder.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles one grant may be held; 0 disables the timeout.
- `CNT_W`, default 5: hold-counter width; must satisfy 2^`CNT_W` > `HOLD_MAX`.

- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  8  request vector, one bit per requester; level-sensitive.
- `i_rr_mode`  in  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
- `i_done`  in  1  current owner releases the resource.
- `o_grant`  out  8  one-hot grant; all zero when idle.
- `o_grant_code`  out  3  binary index of the granted requester; 0 when not busy.
- `o_busy`  out  1  high while a grant is active.
- `o_timeout`  out  1  one-cycle pulse after a forced release.

## Operation
- Reset values: `o_grant` = 0, `o_grant_code` = 0, `o_busy` = 0, `o_timeout` = 0, state = IDLE, hold counter = 0, round-robin pointer `last_id` = 7.
- All outputs are registered.
- State IDLE:
  - If `i_req` is 0, stay in IDLE.
  - Otherwise pick a winner, load `o_grant`/`o_grant_code`, clear the counter, and go to GRANT.
  - `i_rr_mode` is sampled only on this arbitration edge; changing it mid-grant has no effect.
- Fixed priority: winner = highest set bit of `i_req`.
- Round-robin: search indices `last_id`+1, `last_id`+2, … modulo 8; the first set bit wins. Wrap-around 7→0 is mandatory.
- State GRANT (`o_busy` = 1):
  - Counter increments each cycle.
  - Exit to GAP on the first edge where any of the following holds:
    - (a) `i_done` = 1,
    - (b) `i_req[owner]` = 0,
    - (c) `HOLD_MAX` ≠ 0 and counter = `HOLD_MAX`−1.
  - On exit, clear `o_grant`/`o_grant_code`/`o_busy` and set `last_id` = owner, in both modes.
  - If (c) is the only cause, set `o_timeout` for the GAP cycle. If (a) or (b) coincides with (c), treat it as a normal release with no `o_timeout`.
- State GAP: one dead cycle with all grants 0, then go unconditionally to IDLE. This guarantees a turnaround between owners.
- Requests from non-owners during GRANT/GAP are ignored; they compete at the next IDLE arbitration.
- `i_done` while IDLE or GAP is ignored.
- Reset asserted mid-grant: outputs clear asynchronously and immediately. After release, the first arbitration uses `last_id` = 7.

## Timing
- Arbitration latency: a request asserted before edge k (state IDLE) produces a grant visible after edge k.
- Release latency: `i_done` sampled at edge m causes the grant to drop after edge m.
- Minimum spacing from a release edge to the next grant is 2 edges: GAP, then the IDLE arbitration edge.
- Maximum grant length is `HOLD_MAX` cycles. `o_timeout` is high for exactly 1 cycle, coincident with GAP.
- Throughput with continuous requests: one grant per (hold + 2) cycles.
- Combinational paths from inputs to outputs: none.

## Test plan
- Reset/idle: assert `i_rst` mid-grant with `i_req` = 8'b10000000 → `o_grant` = 0 and `o_busy` = 0 immediately; after release with `i_req` = 0, outputs stay 0.
- Fixed priority: `i_rr_mode` = 0, `i_req` = 8'b10010010 → `o_grant` = 8'b10000000, `o_grant_code` = 7; `i_done` → GAP, then the same requester wins again.
- Round-robin rotation: `i_rr_mode` = 1, `i_req` = 8'hFF, pulse `i_done` 1 cycle after each grant → `o_grant_code` sequence 0,1,2,…,7,0 with 2 idle cycles between grants.
- Round-robin skip/wrap: `last_id` = 6, `i_req` = 8'b00000110 → grant code 1 (wraps past 7 and 0).
- Timeout: `HOLD_MAX` = 16, `i_req` = 8'b00000100 held, no `i_done` → grant lasts exactly 16 cycles; `o_timeout` = 1 for 1 cycle; grant code 2 is re-granted 2 edges after release. Repeat with `i_done` on cycle 16 → `o_timeout` stays 0.
- Request drop: owner 5 deasserts `i_req[5]` while `i_req[3]` = 1 → grant drops next edge, then code 3 is granted after the GAP.
